// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a req/ack transaction to
// instruction memory, and hands the fetched word to decode over valid/ready.
// Handles branch/jump redirects from execute and a terminal halt.
module fetch_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic             misalign
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             halt_pending;
  logic             take_halt;
  logic [WIDTH-1:0] redirect_pc;

  // A redirect target is always word aligned; the dropped bits only feed misalign.
  assign redirect_pc = {redirect_addr[WIDTH-1:2], 2'b00};
  assign take_halt   = halt | halt_pending;

  // All outputs come straight from registers or the state code.
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign halted     = (state == HALTED);

  // Next-state selection; a redirect during an unacked request detours through
  // IDLE so req drops for one cycle before the new address is presented.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (redirect)
          state_next = halt_pending ? HALTED : REQ;
        else
          state_next = take_halt ? HALTED : REQ;
      end
      REQ: begin
        if (redirect)
          state_next = halt_pending ? HALTED : (imem_ack ? REQ : IDLE);
        else if (imem_ack)
          state_next = HOLD;
      end
      HOLD: begin
        if (redirect)
          state_next = halt_pending ? HALTED : REQ;
        else if (inst_ready)
          state_next = take_halt ? HALTED : REQ;
      end
      default: state_next = HALTED;
    endcase
  end

  // State register; HALTED is only left through reset.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // PC, captured instruction and sticky misalign flag; redirect beats the
  // normal pc+4 advance and discards data acked in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_ADDR;
      inst     <= '0;
      inst_pc  <= '0;
      misalign <= 1'b0;
    end else if (state != HALTED) begin
      if (redirect) begin
        pc <= redirect_pc;
        if (redirect_addr[1:0] != 2'b00)
          misalign <= 1'b1;
      end else if (state == REQ && imem_ack) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
        pc      <= pc + WIDTH'(4);
      end
    end
  end

  // Remember a halt request until the next request boundary consumes it.
  always_ff @(posedge clk) begin
    if (rst)
      halt_pending <= 1'b0;
    else if (state_next == HALTED)
      halt_pending <= 1'b0;
    else if (halt && state != HALTED)
      halt_pending <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level reference model
// predicts fetch addresses, delivered instructions and status; a separate
// monitor pops the predictions and compares them with what the DUT shows.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic [31:0] pc;
  logic        halted;
  logic        misalign;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .halt(halt), .pc(pc), .halted(halted), .misalign(misalign)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instW;
    logic [31:0] instPc;
    logic        halted;
    logic        misalign;
    logic [31:0] pc;
  } status_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } item_t;

  status_t     statusQ[$];
  logic [31:0] addrQ[$];
  item_t       acceptQ[$];

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, the one instruction offered to
  // decode (if any), idle cycles before the next request, halt bookkeeping.
  logic [31:0] mAddr;
  logic [31:0] mHoldData;
  logic [31:0] mHoldPc;
  bit          mHolding;
  bit          mHalted;
  bit          mPending;
  bit          mMisalign;
  int          mGap;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mAddr     = 32'h0000_3000;
    mHoldData = 32'h0;
    mHoldPc   = 32'h0;
    mHolding  = 1'b0;
    mHalted   = 1'b0;
    mPending  = 1'b0;
    mMisalign = 1'b0;
    mGap      = 1;
  endtask

  // One clock cycle: record the expected status, drive inputs, advance model.
  task automatic applyStimulus(input bit ack, input logic [31:0] data, input bit ready,
                               input bit redir, input logic [31:0] raddr, input bit hlt);
    status_t s;
    item_t   it;
    bit      expReq;
    bit      fire;
    bit      accept;
    bit      oldPending;
    expReq     = !mHalted && !mHolding && (mGap == 0);
    s.req      = expReq;
    s.addr     = mAddr;
    s.valid    = mHolding;
    s.instW    = mHoldData;
    s.instPc   = mHoldPc;
    s.halted   = mHalted;
    s.misalign = mMisalign;
    s.pc       = mAddr;
    statusQ.push_back(s);
    imem_ack      = ack && expReq;
    imem_rdata    = data;
    inst_ready    = ready;
    redirect      = redir;
    redirect_addr = raddr;
    halt          = hlt;
    if (!mHalted) begin
      fire       = expReq && ack;
      accept     = mHolding && ready;
      oldPending = mPending;
      if (fire)
        addrQ.push_back(mAddr);
      if (accept) begin
        it.data = mHoldData;
        it.addr = mHoldPc;
        acceptQ.push_back(it);
      end
      if (redir) begin
        if (raddr[1:0] != 2'b00)
          mMisalign = 1'b1;
        mAddr    = {raddr[31:2], 2'b00};
        mHolding = 1'b0;
        mGap     = (expReq && !fire) ? 1 : 0;
        if (oldPending) begin
          mHalted = 1'b1;
          mGap    = 0;
        end
      end else if (fire) begin
        mHoldData = data;
        mHoldPc   = mAddr;
        mAddr     = mAddr + 32'd4;
        mHolding  = 1'b1;
      end else if (accept || mGap > 0) begin
        mHolding = 1'b0;
        mGap     = 0;
        if (hlt || oldPending)
          mHalted = 1'b1;
      end
      mPending = mHalted ? 1'b0 : (oldPending | hlt);
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    checkOutput("addrQ_drained", addrQ.size(), 0);
    checkOutput("acceptQ_drained", acceptQ.size(), 0);
    rst           = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    inst_ready    = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    halt          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pc", pc, 32'h0000_3000);
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_misalign", misalign, 0);
    rst = 1'b0;
    modelReset();
  endtask

  // Monitor: compares status every driven cycle and pops data expectations
  // whenever the DUT completes a fetch or hands an instruction to decode.
  initial begin
    status_t s;
    item_t   it;
    forever begin
      @(negedge clk);
      #1;
      if (statusQ.size() > 0) begin
        s = statusQ.pop_front();
        checkOutput("imem_req", imem_req, s.req);
        if (s.req)
          checkOutput("imem_addr", imem_addr, s.addr);
        checkOutput("inst_valid", inst_valid, s.valid);
        if (s.valid) begin
          checkOutput("hold_inst", inst, s.instW);
          checkOutput("hold_inst_pc", inst_pc, s.instPc);
        end
        checkOutput("halted", halted, s.halted);
        checkOutput("misalign", misalign, s.misalign);
        checkOutput("pc", pc, s.pc);
        if (imem_req && imem_ack) begin
          if (addrQ.size() > 0)
            checkOutput("fetch_addr", imem_addr, addrQ.pop_front());
          else begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_fetch: actual=%h expected=none", imem_addr);
          end
        end
        if (inst_valid && inst_ready) begin
          if (acceptQ.size() > 0) begin
            it = acceptQ.pop_front();
            checkOutput("accept_inst", inst, it.data);
            checkOutput("accept_inst_pc", inst_pc, it.addr);
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_accept: actual=%h expected=none", inst_pc);
          end
        end
      end
    end
  end

  // Directed scenarios first, then randomized epochs, then the summary.
  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    modelReset();
    doReset();

    // Zero-wait fetch from the reset address, then sequential fetches.
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0);
    applyStimulus(1, 32'h2010_0005, 1, 0, 32'h0, 0);
    checkOutput("tp1_inst", inst, 32'h2010_0005);
    checkOutput("tp1_inst_pc", inst_pc, 32'h0000_3000);
    checkOutput("tp1_pc", pc, 32'h0000_3004);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0);
    checkOutput("tp1_next_req", imem_req, 1);
    checkOutput("tp1_next_addr", imem_addr, 32'h0000_3004);
    applyStimulus(1, 32'h1111_1111, 1, 0, 32'h0, 0);
    checkOutput("tp1_pc2", pc, 32'h0000_3008);

    // Slow memory: three cycles without ack.
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0);
    repeat (3) applyStimulus(0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(1, 32'hAAAA_0001, 0, 0, 32'h0, 0);

    // Decode stalls four cycles, then accepts.
    repeat (4) applyStimulus(0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0);

    // Redirect coincident with ack: data discarded, refetch at target.
    applyStimulus(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_3040, 0);
    checkOutput("tp4_addr", imem_addr, 32'h0000_3040);
    checkOutput("tp4_valid", inst_valid, 0);
    applyStimulus(1, 32'h0BAD_F00D, 0, 0, 32'h0, 0);
    checkOutput("tp4_inst_pc", inst_pc, 32'h0000_3040);

    // Misaligned redirect target is aligned and flagged stickily.
    applyStimulus(0, 32'h0, 1, 1, 32'h0000_3043, 0);
    checkOutput("tp5_pc", pc, 32'h0000_3040);
    repeat (10) applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 0, 32'h0, 0);
    checkOutput("tp5_misalign", misalign, 1);

    // Halt during an outstanding request: fetch delivered, then halted.
    doReset();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1);
    applyStimulus(1, 32'h1234_5678, 0, 0, 32'h0, 0);
    checkOutput("tp6_valid", inst_valid, 1);
    checkOutput("tp6_not_halted", halted, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0);
    checkOutput("tp6_halted", halted, 1);
    checkOutput("tp6_req", imem_req, 0);
    applyStimulus(0, 32'h0, 0, 1, 32'h0000_5000, 0);
    checkOutput("tp6_pc_kept", pc, 32'h0000_3004);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0);

    // Randomized epochs; even epochs keep redirect targets aligned,
    // the last two also inject occasional halts.
    for (int e = 0; e < 6; e++) begin
      doReset();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 7) == 0)
          ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else
          ra = 32'h0000_3000 + 32'($urandom_range(0, 1023));
        if (e % 2 == 0)
          ra[1:0] = 2'b00;
        applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) == 0, ra,
                      (e >= 4) && ($urandom_range(0, 99) == 0));
      end
    end

    doReset();
    @(negedge clk);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
